// File: rtl/pwm_pkg.sv
// Shared types and defaults for the PWM generator.
// Holds the run-state encoding and the default datapath width.
package pwm_pkg;

  localparam int WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    STOP = 2'd2
  } state_t;

endpackage

// File: rtl/pwm_period_cnt.sv
// PWM position counter: counts 0..period while run is high.
// wrap marks the last clock of each PWM cycle.
module pwm_period_cnt
  import pwm_pkg::*;
#(
  parameter int N = WIDTH
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         run,
  input  logic [N-1:0] period,
  output logic [N-1:0] cnt,
  output logic         wrap
);

  localparam logic [N-1:0] ONE = {{(N-1){1'b0}}, 1'b1};

  assign wrap = run && (cnt == period);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (!run || wrap) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + ONE;
    end
  end

endmodule

// File: rtl/pwm_gen.sv
// PWM generator with staged period/duty updates and graceful stop.
// Define PWM_GEN_IRQ_EN to add the sticky irq output and irq_clr input.
module pwm_gen
  import pwm_pkg::*;
#(
  parameter int N = WIDTH
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         en,
  input  logic [N-1:0] period,
  input  logic [N-1:0] duty,
  input  logic         load,
  output logic [N-1:0] cnt,
  output logic         pwm_out,
  output logic         period_end,
`ifdef PWM_GEN_IRQ_EN
  output logic         irq,
  input  logic         irq_clr,
`endif
  output logic         busy
);

  state_t       state;
  logic [N-1:0] per_act;
  logic [N-1:0] duty_act;
  logic [N-1:0] per_stg;
  logic [N-1:0] duty_stg;
  logic         pend;
  logic         wrap;

  assign busy = (state != IDLE);

  pwm_period_cnt #(.N(N)) u_cnt (
    .clock   (clock),
    .reset_n (reset_n),
    .run     (busy),
    .period  (per_act),
    .cnt     (cnt),
    .wrap    (wrap)
  );

  assign period_end = wrap;
  assign pwm_out    = busy && (cnt < duty_act);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      per_act  <= '0;
      duty_act <= '0;
      per_stg  <= '0;
      duty_stg <= '0;
      pend     <= 1'b0;
    end else begin
      if (load) begin
        per_stg  <= period;
        duty_stg <= duty;
      end
      pend <= wrap ? 1'b0 : (pend | load);
      // a load on the wrap clock bypasses staging
      if (wrap) begin
        if (load) begin
          per_act  <= period;
          duty_act <= duty;
        end else if (pend) begin
          per_act  <= per_stg;
          duty_act <= duty_stg;
        end
      end
      unique case (state)
        IDLE: begin
          if (en) begin
            state    <= RUN;
            per_act  <= period;
            duty_act <= duty;
          end
        end
        RUN: begin
          if (!en) state <= wrap ? IDLE : STOP;
        end
        STOP: begin
          if (en)        state <= RUN;
          else if (wrap) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef PWM_GEN_IRQ_EN
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      irq <= 1'b0;
    end else if (wrap) begin
      irq <= 1'b1;
    end else if (irq_clr) begin
      irq <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_pwm_gen.sv
// Self-checking bench for pwm_gen (N=4): vector table plus
// hand sequences for async reset and the optional irq.
module tb_pwm_gen;

  logic       clock;
  logic       reset_n;
  logic       en;
  logic [3:0] period;
  logic [3:0] duty;
  logic       load;
  logic [3:0] cnt;
  logic       pwm_out;
  logic       period_end;
  logic       busy;
`ifdef PWM_GEN_IRQ_EN
  logic       irq;
  logic       irq_clr;
`endif

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic       en;
    logic       load;
    logic [3:0] period;
    logic [3:0] duty;
    logic [3:0] cnt;
    logic       pwm;
    logic       pe;
    logic       busy;
  } vec_t;

  vec_t tbl[$];
  vec_t sb[$];

  pwm_gen #(.N(4)) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .en         (en),
    .period     (period),
    .duty       (duty),
    .load       (load),
    .cnt        (cnt),
    .pwm_out    (pwm_out),
    .period_end (period_end),
`ifdef PWM_GEN_IRQ_EN
    .irq        (irq),
    .irq_clr    (irq_clr),
`endif
    .busy       (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic add(input logic e, input logic l,
                     input logic [3:0] p, input logic [3:0] d,
                     input logic [3:0] c, input logic w,
                     input logic pe, input logic b);
    vec_t v;
    v.en = e; v.load = l; v.period = p; v.duty = d;
    v.cnt = c; v.pwm = w; v.pe = pe; v.busy = b;
    tbl.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic outs(input string name, input logic [3:0] c,
                      input logic w, input logic pe, input logic b);
    check(name, {25'd0, cnt, pwm_out, period_end, busy},
          {25'd0, c, w, pe, b});
  endtask

  task automatic tick();
    @(posedge clock);
    @(negedge clock);
  endtask

  initial begin
    vec_t e;
    // basic waveform p=4 d=2
    add(1,0,4,2, 0,1,0,1);
    add(1,0,4,2, 1,1,0,1);
    add(1,0,4,2, 2,0,0,1);
    add(1,0,4,2, 3,0,0,1);
    add(1,0,4,2, 4,0,1,1);
    add(1,0,4,2, 0,1,0,1);
    add(1,0,4,2, 1,1,0,1);
    // shadow load duty=4 mid-cycle
    add(1,1,4,4, 2,0,0,1);
    add(1,0,4,2, 3,0,0,1);
    add(1,0,4,2, 4,0,1,1);
    add(1,0,4,2, 0,1,0,1);
    add(1,0,4,2, 1,1,0,1);
    add(1,0,4,2, 2,1,0,1);
    add(1,0,4,2, 3,1,0,1);
    add(1,0,4,2, 4,0,1,1);
    add(1,0,4,2, 0,1,0,1);
    // stage duty=2, then graceful stop at cnt=1
    add(1,1,4,2, 1,1,0,1);
    add(0,0,4,2, 2,1,0,1);
    add(0,0,4,2, 3,1,0,1);
    add(0,0,4,2, 4,0,1,1);
    add(0,0,4,2, 0,0,0,0);
    add(0,0,4,2, 0,0,0,0);
    // restart, stop at cnt=1, resume at cnt=3
    add(1,0,4,2, 0,1,0,1);
    add(1,0,4,2, 1,1,0,1);
    add(0,0,4,2, 2,0,0,1);
    add(0,0,4,2, 3,0,0,1);
    add(1,0,4,2, 4,0,1,1);
    add(1,0,4,2, 0,1,0,1);
    add(1,0,4,2, 1,1,0,1);
    add(1,0,4,2, 2,0,0,1);
    add(1,0,4,2, 3,0,0,1);
    add(1,0,4,2, 4,0,1,1);
    // load coinciding with wrap: p=2 d=1 immediately
    add(1,1,2,1, 0,1,0,1);
    add(1,0,9,9, 1,0,0,1);
    add(1,0,9,9, 2,0,1,1);
    add(1,0,9,9, 0,1,0,1);
    // duty=0 extreme
    add(1,1,4,0, 1,0,0,1);
    add(1,0,9,9, 2,0,1,1);
    add(1,0,9,9, 0,0,0,1);
    add(1,0,9,9, 1,0,0,1);
    add(1,0,9,9, 2,0,0,1);
    add(1,0,9,9, 3,0,0,1);
    add(1,0,9,9, 4,0,1,1);
    add(1,0,9,9, 0,0,0,1);
    // duty=7 > period=4
    add(1,1,4,7, 1,0,0,1);
    add(1,0,9,9, 2,0,0,1);
    add(1,0,9,9, 3,0,0,1);
    add(1,0,9,9, 4,0,1,1);
    add(1,0,9,9, 0,1,0,1);
    add(1,0,9,9, 1,1,0,1);
    add(1,0,9,9, 2,1,0,1);
    add(1,0,9,9, 3,1,0,1);
    add(1,0,9,9, 4,1,1,1);
    // period=0
    add(1,1,0,1, 0,1,1,1);
    add(1,0,9,9, 0,1,1,1);
    add(1,0,9,9, 0,1,1,1);

    reset_n = 1'b0;
    en = 1'b0; load = 1'b0; period = '0; duty = '0;
`ifdef PWM_GEN_IRQ_EN
    irq_clr = 1'b0;
`endif
    repeat (2) @(negedge clock);
    outs("reset_state", 0, 0, 0, 0);
    reset_n = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      en = tbl[i].en; load = tbl[i].load;
      period = tbl[i].period; duty = tbl[i].duty;
      sb.push_back(tbl[i]);
      tick();
      e = sb.pop_front();
      check($sformatf("vec%0d", i),
            {25'd0, cnt, pwm_out, period_end, busy},
            {25'd0, e.cnt, e.pwm, e.pe, e.busy});
    end

    // async reset from a running state
    reset_n = 1'b0;
    #1 outs("rst_async_a", 0, 0, 0, 0);
    en = 1'b1; load = 1'b0; period = 4; duty = 2;
    @(negedge clock);
    reset_n = 1'b1;
    tick(); outs("rst_start_c0", 0, 1, 0, 1);
    tick(); outs("rst_start_c1", 1, 1, 0, 1);
    tick(); outs("rst_start_c2", 2, 0, 0, 1);
    #2 reset_n = 1'b0;
    #1 outs("rst_async_mid", 0, 0, 0, 0);
    @(negedge clock);
    reset_n = 1'b1;
    tick(); outs("rst_restart_c0", 0, 1, 0, 1);
    tick(); outs("rst_restart_c1", 1, 1, 0, 1);

`ifdef PWM_GEN_IRQ_EN
    check("irq_after_reset", irq, 0);
    tick(); tick(); tick();
    outs("irq_pe_cycle", 4, 0, 1, 1);
    check("irq_before_set", irq, 0);
    tick(); check("irq_set", irq, 1);
    tick(); irq_clr = 1'b1;
    tick(); irq_clr = 1'b0;
    check("irq_cleared", irq, 0);
    tick(); tick();
    outs("irq_wrap_cycle", 4, 0, 1, 1);
    irq_clr = 1'b1;
    tick(); irq_clr = 1'b0;
    check("irq_set_wins", irq, 1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pwm_gen.md
PWM_GEN -- requirements
Module: pwm_gen

Interface
REQ-001 Parameter N, default 8: width of counter, period and duty.
REQ-002 clock  input  1  single clock; all state updates on posedge.
REQ-003 reset_n  input  1  asynchronous, active-low reset.
REQ-004 en  input  1  run request; level-sensitive.
REQ-005 period  input  N  terminal count; PWM cycle length is period+1 clocks.
REQ-006 duty  input  N  number of high clocks per PWM cycle.
REQ-007 load  input  1  one-clock strobe; captures period/duty into staging registers.
REQ-008 cnt  output  N  current position within the PWM cycle.
REQ-009 pwm_out  output  1  PWM waveform.
REQ-010 period_end  output  1  high while cnt equals the active period and state is not IDLE.
REQ-011 busy  output  1  high in RUN and STOP.

Function
REQ-012 The block SHALL implement the states IDLE, RUN and STOP.
REQ-013 IDLE->RUN on en=1: active period/duty loaded from the period/duty inputs; cnt=0 in the first RUN cycle.
REQ-014 In RUN/STOP, cnt SHALL increment by 1 per clock and return to 0 on the clock after cnt==active period (wrap).
REQ-015 At each wrap, staging values SHALL become active if a load occurred since the previous transfer.
REQ-016 If load and wrap coincide, the period/duty input values SHALL become active at that wrap.
REQ-017 pwm_out SHALL be 1 iff busy and cnt < active duty.
REQ-018 Boundary conditions:
- duty=0 gives constant 0.
- duty>period gives constant 1 while busy.
REQ-019 period=0: cnt holds 0 and period_end is high every busy cycle.
REQ-020 RUN->STOP when en=0; the current PWM cycle SHALL complete unchanged.
REQ-021 STOP->RUN if en=1 before the wrap, with no discontinuity in cnt.
REQ-022 STOP->IDLE at the wrap if en is still 0; cnt=0 in IDLE.
REQ-023 In IDLE: cnt=0, pwm_out=0, period_end=0, busy=0; load still updates staging.
REQ-024 All outputs SHALL be combinational functions of registers only; there is no input-to-output path.
REQ-025 Counter arithmetic SHALL be N bits, unsigned; cnt never exceeds the active period.

Reset
REQ-026 reset_n=0 SHALL asynchronously force: state IDLE; cnt, active and staging period/duty 0; load-pending flag 0; irq 0 if present.
REQ-027 Reset asserted mid-cycle SHALL abort the PWM cycle immediately; pwm_out drops in the same timestep.
REQ-028 Release of reset SHALL take effect at the next posedge clock.

Configuration
REQ-029 Macro PWM_GEN_IRQ_EN defined: adds ports irq (output 1) and irq_clr (input 1).
- irq sets on any period_end cycle and is sticky.
- irq_clr clears irq; set wins over a simultaneous irq_clr.
REQ-030 Macro PWM_GEN_IRQ_EN undefined: no irq/irq_clr ports and no irq logic; all other behaviour identical.

Structure
REQ-031 Package pwm_pkg SHALL hold the state enum typedef (IDLE, RUN, STOP) and the default width constant, 8.
REQ-032 The cnt register, its wrap compare and period_end SHALL be one sub-module, pwm_period_cnt (parameter N; inputs clock, reset_n, run, period; outputs cnt, wrap).

Verification
REQ-033 The bench SHALL cover these scenarios (N=4 unless stated; checks on negedge clock):
- Basic waveform: reset, period=4, duty=2, en=1. Expect cnt 0,1,2,3,4,0; pwm_out 1,1,0,0,0 repeating; period_end high when cnt=4.
- Shadow update: period=4, duty=2 running; load with duty=4 mid-cycle. Expect the current cycle unchanged and 4 high clocks from the next wrap.
- Graceful stop: en=0 at cnt=1 (period=4). Expect busy through cnt=4, then IDLE with cnt=0 and pwm_out=0. Variant: en=1 again at cnt=3; expect no gap.
- Extremes: duty=0 gives pwm_out always 0; duty=7, period=4 gives always 1; period=0 gives cnt=0 and period_end=1 every cycle.
- Async reset: reset_n=0 at cnt=2 between clock edges. Expect cnt=0 and pwm_out=0 immediately; restart from cnt=0 after release with en=1.
- With PWM_GEN_IRQ_EN defined: irq=1 after the first period_end; irq_clr on a non-wrap cycle clears it; irq_clr on a wrap cycle leaves irq=1.
